// File: rtl/lcd_controller_scan_pkg.sv
// Shared opcodes, constants and scan FSM state type for the LCD controller.
package lcd_pkg;

  localparam logic [5:0] CONTRAST_RESET = 6'h20;
  localparam logic [5:0] CONTRAST_MAX   = 6'h3F;

  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_SEG_NORM   = 8'hA0;
  localparam logic [7:0] OP_SEG_REV    = 8'hA1;
  localparam logic [7:0] OP_MAXC_OFF   = 8'hA2;
  localparam logic [7:0] OP_MAXC_ON    = 8'hA3;
  localparam logic [7:0] OP_ALL_OFF    = 8'hA4;
  localparam logic [7:0] OP_ALL_ON     = 8'hA5;
  localparam logic [7:0] OP_INV_OFF    = 8'hA6;
  localparam logic [7:0] OP_INV_ON     = 8'hA7;
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_RMW_ENTER  = 8'hE0;
  localparam logic [7:0] OP_SOFT_RESET = 8'hE2;
  localparam logic [7:0] OP_RMW_EXIT   = 8'hEE;

  // Upper-nibble prefixes of the ranged opcodes
  localparam logic [3:0] PFX_COL_LO  = 4'h0;
  localparam logic [3:0] PFX_COL_HI  = 4'h1;
  localparam logic [3:0] PFX_PAGE    = 4'hB;
  localparam logic [3:0] PFX_ROW_ORD = 4'hC;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_FETCH,
    SCAN_EMIT
  } scan_state_t;

endpackage

// File: rtl/lcd_fb_ram.sv
// Page-organised framebuffer: CPU write/read port plus independent scan read port.
module lcd_fb_ram #(
  parameter  int DEPTH = 1188,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DEPTH];

  // Read-before-write on both ports: a same-cycle write is not visible to either read
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/lcd_controller_scan.sv
// LCD controller: CPU command/data register decode, framebuffer RAM and a
// valid/ready scanout engine applying start line, row/segment order and display modes.
module lcd_controller_scan
  import lcd_pkg::*;
#(
  parameter  int          COLS      = 132,
  parameter  int          PAGES     = 9,
  parameter  int          VIS_COLS  = 96,
  parameter  int          VIS_ROWS  = 64,
  parameter  logic [23:0] CMD_ADDR  = 24'h20FE,
  parameter  logic [23:0] DATA_ADDR = 24'h20FF,
  localparam int          XW        = $clog2(VIS_COLS),
  localparam int          YW        = $clog2(VIS_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_ce,
  input  logic          bus_write,
  input  logic          bus_read,
  input  logic [23:0]   address_in,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  output logic [5:0]    lcd_contrast,
  input  logic          frame_start,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_on,
  output logic          frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(COLS * PAGES);

  // Bus-side registers
  logic          wr_prev, rd_prev;
  logic [5:0]    contrast;
  logic          contrast_set;
  logic [CW-1:0] column, saved_col;
  logic [3:0]    page;
  logic [5:0]    start_line;
  logic          seg_dir, all_on, invert, display_en, row_order, rmw;

  logic          is_cmd, is_data, wr_edge, rd_edge, soft_reset;
  logic          cpu_ok, ram_we;
  logic [CW-1:0] cpu_col;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    ram_a_rdata, ram_b_rdata;

  // Scan-side registers
  scan_state_t   state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          done_nx, last_pix;
  logic [5:0]    r_row, phys_row;
  logic [CW-1:0] scan_col;
  logic [AW-1:0] scan_addr;
  logic [2:0]    s_bit;
  logic          s_den, s_all, s_inv;

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c >= CW'(COLS - 1)) ? CW'(COLS - 1) : c + 1'b1;
  endfunction

  assign is_cmd     = (address_in == CMD_ADDR);
  assign is_data    = (address_in == DATA_ADDR);
  assign wr_edge    = clk_ce && bus_write && !wr_prev;
  assign rd_edge    = clk_ce && bus_read && !rd_prev && !wr_edge;
  assign soft_reset = wr_edge && is_cmd && !contrast_set && (data_in == OP_SOFT_RESET);

  assign cpu_ok   = (int'(page) < PAGES) && (int'(column) < COLS);
  assign cpu_col  = seg_dir ? CW'(COLS - 1) - column : column;
  assign cpu_addr = cpu_ok ? AW'(page) * AW'(COLS) + AW'(cpu_col) : '0;
  assign ram_we   = wr_edge && is_data && !contrast_set && cpu_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
    end else if (clk_ce) begin
      wr_prev <= bus_write;
      rd_prev <= bus_read;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      contrast     <= CONTRAST_RESET;
      contrast_set <= 1'b0;
      column       <= '0;
      saved_col    <= '0;
      page         <= '0;
      start_line   <= '0;
      seg_dir      <= 1'b0;
      all_on       <= 1'b0;
      invert       <= 1'b0;
      display_en   <= 1'b0;
      row_order    <= 1'b0;
      rmw          <= 1'b0;
    end else if (wr_edge && (is_cmd || is_data) && contrast_set) begin
      contrast     <= data_in[5:0];
      contrast_set <= 1'b0;
    end else if (wr_edge && is_data) begin
      column <= col_inc(column);
    end else if (wr_edge && is_cmd) begin
      case (data_in[7:4])
        PFX_COL_LO:  if (!rmw) column[3:0] <= data_in[3:0];
        PFX_COL_HI:  if (!rmw) column <= CW'({data_in[3:0], column[3:0]});
        4'h4, 4'h5, 4'h6, 4'h7: start_line <= data_in[5:0];
        PFX_PAGE:    page <= data_in[3:0];
        PFX_ROW_ORD: row_order <= data_in[3];
        default: begin
          // max_contrast (A2/A3) is accepted but has no visible effect here, so it is not stored
          case (data_in)
            OP_CONTRAST:             contrast_set <= 1'b1;
            OP_SEG_NORM, OP_SEG_REV: seg_dir <= data_in[0];
            OP_ALL_OFF, OP_ALL_ON:   all_on <= data_in[0];
            OP_INV_OFF, OP_INV_ON:   invert <= data_in[0];
            OP_DISP_OFF, OP_DISP_ON: display_en <= data_in[0];
            OP_MAXC_OFF, OP_MAXC_ON: ;
            OP_RMW_ENTER: begin
              rmw       <= 1'b1;
              saved_col <= column;
            end
            OP_RMW_EXIT: begin
              if (rmw) column <= saved_col;
              rmw <= 1'b0;
            end
            default: ;
          endcase
        end
      endcase
    end else if (rd_edge && is_cmd && contrast_set) begin
      contrast     <= CONTRAST_MAX;
      contrast_set <= 1'b0;
    end else if (rd_edge && is_data && !rmw) begin
      column <= col_inc(column);
    end
  end

  always_comb begin
    data_out = '0;
    if (!contrast_set) begin
      if (is_cmd) begin
        data_out = 8'h40 | {2'b00, display_en, 5'b00000};
      end else if (is_data && int'(page) < PAGES) begin
        data_out = (int'(page) == PAGES - 1) ? {7'b0, ram_a_rdata[0]} : ram_a_rdata;
      end
    end
  end

  assign lcd_contrast = contrast;

  // Scanout address mapping
  assign r_row     = 6'(y) + start_line;
  assign phys_row  = row_order ? 6'd63 - r_row : r_row;
  assign scan_col  = seg_dir ? CW'(COLS - 1) - CW'(x) : CW'(x);
  assign scan_addr = AW'(phys_row[5:3]) * AW'(COLS) + AW'(scan_col);
  assign last_pix  = (x == XW'(VIS_COLS - 1)) && (y == YW'(VIS_ROWS - 1));

  lcd_fb_ram #(.DEPTH(COLS * PAGES)) u_ram (
    .clk     (clk),
    .a_we    (ram_we),
    .a_addr  (cpu_addr),
    .a_wdata (data_in),
    .a_rdata (ram_a_rdata),
    .b_en    (state == SCAN_FETCH),
    .b_addr  (scan_addr),
    .b_rdata (ram_b_rdata)
  );

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      SCAN_IDLE:  if (frame_start) state_nx = SCAN_FETCH;
      SCAN_FETCH: state_nx = SCAN_EMIT;
      SCAN_EMIT: begin
        if (pix_ready) begin
          if (last_pix) begin
            state_nx = SCAN_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = SCAN_FETCH;
          end
        end
      end
      default: state_nx = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN_IDLE;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      s_bit      <= '0;
      s_den      <= 1'b0;
      s_all      <= 1'b0;
      s_inv      <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= done_nx;
      if (state == SCAN_IDLE && frame_start) begin
        x <= '0;
        y <= '0;
      end
      // Modes are captured with the RAM read so a held pixel cannot change under stall
      if (state == SCAN_FETCH) begin
        s_bit <= phys_row[2:0];
        s_den <= display_en;
        s_all <= all_on;
        s_inv <= invert;
      end
      if (state == SCAN_EMIT && pix_ready) begin
        if (x == XW'(VIS_COLS - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign pix_valid = (state == SCAN_EMIT);
  assign pix_x     = x;
  assign pix_y     = y;
  assign pix_on    = s_den & (s_all | (ram_b_rdata[s_bit] ^ s_inv));

endmodule

// File: tb/tb_lcd_controller_scan.sv
// Directed bench for lcd_controller_scan: register decode, framebuffer access and scanout.
module tb_lcd_controller_scan;

  localparam logic [23:0] CMD  = 24'h20FE;
  localparam logic [23:0] DATA = 24'h20FF;
  localparam int NPIX = 96 * 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_ce = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] address_in = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [5:0]  lcd_contrast;
  logic        frame_start = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_on;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fb [0:7][0:131];
  int m_sl = 0, m_ro = 0, m_sd = 0, m_inv = 0, m_all = 0, m_den = 0;

  lcd_controller_scan #(
    .COLS(132), .PAGES(9), .VIS_COLS(96), .VIS_ROWS(64),
    .CMD_ADDR(24'h20FE), .DATA_ADDR(24'h20FF)
  ) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce),
    .bus_write(bus_write), .bus_read(bus_read),
    .address_in(address_in), .data_in(data_in), .data_out(data_out),
    .lcd_contrast(lcd_contrast),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    address_in = a;
    data_in    = d;
    bus_write  = 1'b1;
    @(posedge clk); #1;
    bus_write  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] d);
    address_in = a;
    @(negedge clk);
    d = data_out;
    bus_read = 1'b1;
    @(posedge clk); #1;
    bus_read = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic exp_pix(input int x, input int y);
    int r, phys, col;
    logic [7:0] w;
    r    = (y + m_sl) % 64;
    phys = (m_ro != 0) ? 63 - r : r;
    col  = (m_sd != 0) ? 131 - x : x;
    w    = fb[phys / 8][col];
    if (m_den == 0) return 1'b0;
    if (m_all != 0) return 1'b1;
    return w[phys % 8] ^ (m_inv != 0);
  endfunction

  task automatic test_reset();
    logic [7:0] d;
    vectors++;
    if (lcd_contrast !== 6'h20) begin
      miscompares++; $display("FAIL reset_contrast got %h want 20", lcd_contrast);
    end
    vectors++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_scan got valid=%b done=%b want 0 0", pix_valid, frame_done);
    end
    vectors++;
    if (dut.column !== 8'd0) begin
      miscompares++; $display("FAIL reset_column got %0d want 0", dut.column);
    end
    rd(CMD, d);
    vectors++;
    if (d !== 8'h40) begin
      miscompares++; $display("FAIL reset_status got %h want 40", d);
    end
  endtask

  task automatic test_contrast();
    logic [7:0] d;
    wr(CMD, 8'h81);
    rd(CMD, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL status_while_set got %h want 00", d);
    end
    vectors++;
    if (lcd_contrast !== 6'h3F) begin
      miscompares++; $display("FAIL contrast_read_max got %h want 3f", lcd_contrast);
    end
    wr(CMD, 8'h81);
    wr(CMD, 8'h15);
    vectors++;
    if (lcd_contrast !== 6'h15) begin
      miscompares++; $display("FAIL contrast_set got %h want 15", lcd_contrast);
    end
    rd(CMD, d);
    vectors++;
    if (d !== 8'h40) begin
      miscompares++; $display("FAIL status_after_set got %h want 40", d);
    end
    clk_ce = 1'b0;
    wr(CMD, 8'h81);
    wr(CMD, 8'h30);
    clk_ce = 1'b1;
    vectors++;
    if (lcd_contrast !== 6'h15) begin
      miscompares++; $display("FAIL ce_gating got %h want 15", lcd_contrast);
    end
    rd(CMD, d);
    vectors++;
    if (d !== 8'h40) begin
      miscompares++; $display("FAIL ce_gating_status got %h want 40", d);
    end
  endtask

  task automatic test_data_write();
    logic [7:0] d;
    wr(CMD, 8'hB2); wr(CMD, 8'h10); wr(CMD, 8'h05);
    wr(DATA, 8'hAA); wr(DATA, 8'h55);
    vectors++;
    if (dut.column !== 8'd7) begin
      miscompares++; $display("FAIL col_after_writes got %0d want 7", dut.column);
    end
    wr(CMD, 8'h10); wr(CMD, 8'h05);
    rd(DATA, d);
    vectors++;
    if (d !== 8'hAA) begin
      miscompares++; $display("FAIL ram_2_5 got %h want aa", d);
    end
    rd(DATA, d);
    vectors++;
    if (d !== 8'h55) begin
      miscompares++; $display("FAIL ram_2_6 got %h want 55", d);
    end
    for (int i = 0; i < 200; i++) wr(DATA, 8'h00);
    vectors++;
    if (dut.column !== 8'd131) begin
      miscompares++; $display("FAIL col_saturate got %0d want 131", dut.column);
    end
    wr(CMD, 8'hB8); wr(CMD, 8'h10); wr(CMD, 8'h00);
    wr(DATA, 8'hA5);
    wr(CMD, 8'h10); wr(CMD, 8'h00);
    rd(DATA, d);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++; $display("FAIL last_page_bit0 got %h want 01", d);
    end
    wr(CMD, 8'hB9); wr(CMD, 8'h10); wr(CMD, 8'h00);
    wr(DATA, 8'hFF);
    wr(CMD, 8'h10); wr(CMD, 8'h00);
    rd(DATA, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL page_out_of_range got %h want 00", d);
    end
  endtask

  task automatic test_rmw();
    logic [7:0] d;
    wr(CMD, 8'hB2); wr(CMD, 8'h10); wr(CMD, 8'h05);
    wr(CMD, 8'hE0);
    for (int i = 0; i < 3; i++) begin
      rd(DATA, d);
      vectors++;
      if (d !== 8'hAA) begin
        miscompares++; $display("FAIL rmw_read%0d got %h want aa", i, d);
      end
    end
    wr(CMD, 8'h03);
    vectors++;
    if (dut.column !== 8'd5) begin
      miscompares++; $display("FAIL rmw_col_hold got %0d want 5", dut.column);
    end
    wr(DATA, 8'hAA);
    vectors++;
    if (dut.column !== 8'd6) begin
      miscompares++; $display("FAIL rmw_write_inc got %0d want 6", dut.column);
    end
    wr(CMD, 8'hEE);
    vectors++;
    if (dut.column !== 8'd5) begin
      miscompares++; $display("FAIL rmw_restore got %0d want 5", dut.column);
    end
    rd(DATA, d);
    vectors++;
    if (dut.column !== 8'd6) begin
      miscompares++; $display("FAIL post_rmw_read_inc got %0d want 6", dut.column);
    end
  endtask

  task automatic fill_fb();
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 132; c++)
        fb[p][c] = 8'((p * 37 + c * 11) ^ 8'h5A);
    fb[0][0] = 8'h01;
    fb[0][1] = 8'hFE;
    for (int p = 0; p < 8; p++) begin
      wr(CMD, 8'(8'hB0 + p)); wr(CMD, 8'h10); wr(CMD, 8'h00);
      for (int c = 0; c < 132; c++) wr(DATA, fb[p][c]);
    end
  endtask

  task automatic run_frame(input bit stall, input int restart_at, input int reset_at);
    int n, cyc, dones, first_cyc, last_cyc, limit;
    bit pv, pr, restarted;
    logic [6:0] px;
    logic [5:0] py;
    logic pon;
    limit = (reset_at >= 0) ? reset_at + 1 : NPIX;
    n = 0; cyc = 0; dones = 0; first_cyc = -1; last_cyc = 0;
    pv = 0; pr = 0; restarted = 0; px = '0; py = '0; pon = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_latency got valid=%b want 0", pix_valid);
    end
    while (n < limit && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (frame_done) dones++;
      if (pix_valid && pv && !pr) begin
        vectors++;
        if (pix_x !== px || pix_y !== py || pix_on !== pon) begin
          miscompares++;
          $display("FAIL stall_stable got (%0d,%0d)=%b want (%0d,%0d)=%b", pix_x, pix_y, pix_on, px, py, pon);
        end
      end else if (pix_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        vectors++;
        if (pix_x !== 7'(n % 96) || pix_y !== 6'(n / 96) || pix_on !== exp_pix(n % 96, n / 96)) begin
          miscompares++;
          $display("FAIL pixel%0d got (%0d,%0d)=%b want (%0d,%0d)=%b", n, pix_x, pix_y, pix_on,
                   n % 96, n / 96, exp_pix(n % 96, n / 96));
        end
        n++;
      end
      pv = pix_valid; px = pix_x; py = pix_y; pon = pix_on;
      frame_start = (restart_at >= 0 && n == restart_at && !restarted);
      if (frame_start) restarted = 1;
      pix_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      pr = pix_ready;
    end
    frame_start = 1'b0;
    vectors++;
    if (n != limit) begin
      miscompares++; $display("FAIL pixel_count got %0d want %0d", n, limit);
    end
    vectors++;
    if (first_cyc != 1) begin
      miscompares++; $display("FAIL first_valid_cycle got %0d want 1", first_cyc);
    end
    if (reset_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if (pix_valid !== 1'b0 || frame_done !== 1'b0 || lcd_contrast !== 6'h20) begin
        miscompares++;
        $display("FAIL reset_mid_frame got valid=%b done=%b contrast=%h want 0 0 20",
                 pix_valid, frame_done, lcd_contrast);
      end
      dones = 0; n = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (frame_done) dones++;
        if (pix_valid) n++;
      end
      vectors++;
      if (dones != 0 || n != 0) begin
        miscompares++; $display("FAIL idle_after_reset got valids=%0d dones=%0d want 0 0", n, dones);
      end
      return;
    end
    if (!stall) begin
      vectors++;
      if (last_cyc - first_cyc != 2 * (NPIX - 1)) begin
        miscompares++; $display("FAIL throughput got %0d cycles want %0d", last_cyc - first_cyc, 2 * (NPIX - 1));
      end
    end
    pix_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++; $display("FAIL frame_done_timing got %b want 1", frame_done);
    end
    for (int k = 0; k < 10; k++) begin
      if (frame_done) dones++;
      @(negedge clk);
    end
    vectors++;
    if (dones != 1 || pix_valid !== 1'b0) begin
      miscompares++; $display("FAIL frame_done_count got %0d valid=%b want 1 0", dones, pix_valid);
    end
  endtask

  task automatic test_frame_basic();
    logic [7:0] d;
    wr(CMD, 8'hAF); m_den = 1;
    wr(CMD, 8'h40); m_sl = 0;
    rd(CMD, d);
    vectors++;
    if (d !== 8'h60) begin
      miscompares++; $display("FAIL status_display_on got %h want 60", d);
    end
    run_frame(1'b0, -1, -1);
  endtask

  task automatic test_mapping_stall();
    wr(CMD, 8'h7F); m_sl = 63;
    wr(CMD, 8'hC8); m_ro = 1;
    wr(CMD, 8'hA1); m_sd = 1;
    wr(CMD, 8'hA7); m_inv = 1;
    run_frame(1'b1, 500, -1);
  endtask

  task automatic test_modes();
    wr(CMD, 8'hA5); m_all = 1;
    run_frame(1'b0, -1, -1);
    wr(CMD, 8'hAE); m_den = 0;
    run_frame(1'b0, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    wr(CMD, 8'hAF); m_den = 1;
    wr(CMD, 8'hA4); m_all = 0;
    run_frame(1'b0, -1, 1000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_contrast();
    test_data_write();
    test_rmw();
    fill_fb();
    test_frame_basic();
    test_mapping_stall();
    test_modes();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
